param_table_fsm: RTL and testbench

Table-driven, parametrised Moore FSM. It is the programmable successor to the team's fixed 5-state, 2-bit-in/2-bit-out lab FSMs. Transition and output tables live in registers and are written through a config port. The FSM advances one transition per accepted input symbol and exposes its state, a step counter and a sticky illegal-state error.

---
 rtl/param_table_fsm_pkg.sv | 33 +++
 rtl/param_table_fsm_if.sv | 36 +++
 rtl/param_table_fsm_tbl_regs.sv | 78 +++++++
 rtl/param_table_fsm.sv | 90 +++++++++
 tb/tb_param_table_fsm.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/param_table_fsm_pkg.sv
// Shared constants, helper function and readable state names for the
// table-driven FSM and its benches.
package param_table_fsm_pkg;

    // Ceiling log2, used to size state encodings from a state count.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    localparam int DEF_IN_W       = 2;
    localparam int DEF_OUT_W      = 2;
    localparam int DEF_NUM_STATES = 5;
    localparam int DEF_STATE_W    = clog2(DEF_NUM_STATES);
    localparam int DEF_CNT_W      = 8;

    // Names for the classic five-state lab machine.
    typedef enum logic [2:0] {
        S_A = 3'd0,
        S_B = 3'd1,
        S_C = 3'd2,
        S_D = 3'd3,
        S_E = 3'd4
    } fsm5_state_e;

endpackage

// File: rtl/param_table_fsm_if.sv
// Symbol, configuration and status signals of the table-driven FSM.
// The master drives symbols and table writes; the slave is the FSM.
interface param_table_fsm_if
    import param_table_fsm_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int STATE_W = DEF_STATE_W,
    parameter int CNT_W   = DEF_CNT_W
);
    logic               in_valid;
    logic [IN_W-1:0]    in;
    logic               cfg_tr_we;
    logic               cfg_out_we;
    logic [STATE_W-1:0] cfg_state;
    logic [IN_W-1:0]    cfg_in;
    logic [STATE_W-1:0] cfg_next;
    logic [OUT_W-1:0]   cfg_out;
    logic               err_clr;
    logic [OUT_W-1:0]   out;
    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   step_cnt;
    logic               err;

    modport master (
        output in_valid, in, cfg_tr_we, cfg_out_we, cfg_state, cfg_in,
               cfg_next, cfg_out, err_clr,
        input  out, state, step_cnt, err
    );

    modport slave (
        input  in_valid, in, cfg_tr_we, cfg_out_we, cfg_state, cfg_in,
               cfg_next, cfg_out, err_clr,
        output out, state, step_cnt, err
    );
endinterface

// File: rtl/param_table_fsm_tbl_regs.sv
// Transition and output register files. Only legal rows are stored;
// writes to rows at or beyond NUM_STATES are dropped. Reads are
// combinational so a step sees the contents from before any same-cycle write.
module fsm_tbl_regs
    import param_table_fsm_pkg::*;
#(
    parameter int                 IN_W        = DEF_IN_W,
    parameter int                 OUT_W       = DEF_OUT_W,
    parameter int                 NUM_STATES  = DEF_NUM_STATES,
    parameter int                 STATE_W     = DEF_STATE_W,
    parameter logic [STATE_W-1:0] RESET_STATE = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tr_we,
    input  logic               out_we,
    input  logic [STATE_W-1:0] wr_state,
    input  logic [IN_W-1:0]    wr_in,
    input  logic [STATE_W-1:0] wr_next,
    input  logic [OUT_W-1:0]   wr_out,
    input  logic [STATE_W-1:0] rd_state,
    input  logic [IN_W-1:0]    rd_in,
    output logic [STATE_W-1:0] rd_next,
    output logic [OUT_W-1:0]   rd_out
);

    localparam int               NUM_COLS  = 2 ** IN_W;
    localparam logic [STATE_W:0] NUM_ST_L  = (STATE_W + 1)'(NUM_STATES);

    logic [STATE_W-1:0] tr_q  [NUM_STATES][NUM_COLS];
    logic [STATE_W-1:0] tr_d  [NUM_STATES][NUM_COLS];
    logic [OUT_W-1:0]   out_q [NUM_STATES];
    logic [OUT_W-1:0]   out_d [NUM_STATES];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = ({1'b0, wr_state} < NUM_ST_L);
    assign rd_ok = ({1'b0, rd_state} < NUM_ST_L);

    // Next table contents: copy, then apply whichever writes are enabled.
    always_comb begin
        tr_d  = tr_q;
        out_d = out_q;
        if (tr_we && wr_ok) begin
            tr_d[wr_state][wr_in] = wr_next;
        end
        if (out_we && wr_ok) begin
            out_d[wr_state] = wr_out;
        end
    end

    // Table storage; reset points every transition home and zeroes outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < NUM_STATES; s++) begin
                out_q[s] <= '0;
                for (int c = 0; c < NUM_COLS; c++) begin
                    tr_q[s][c] <= RESET_STATE;
                end
            end
        end else begin
            tr_q  <= tr_d;
            out_q <= out_d;
        end
    end

    // Read ports; an out-of-range row reads as a safe default.
    always_comb begin
        rd_next = RESET_STATE;
        rd_out  = '0;
        if (rd_ok) begin
            rd_next = tr_q[rd_state][rd_in];
            rd_out  = out_q[rd_state];
        end
    end

endmodule

// File: rtl/param_table_fsm.sv
// Table-driven Moore FSM: one transition per accepted symbol, a saturating
// step counter and a sticky flag for steps that land on an illegal state.
module param_table_fsm
    import param_table_fsm_pkg::*;
#(
    parameter int                 IN_W        = DEF_IN_W,
    parameter int                 OUT_W       = DEF_OUT_W,
    parameter int                 NUM_STATES  = DEF_NUM_STATES,
    parameter int                 STATE_W     = DEF_STATE_W,
    parameter logic [STATE_W-1:0] RESET_STATE = '0,
    parameter int                 CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    param_table_fsm_if.slave  bus
);

    localparam logic [STATE_W:0] NUM_ST_L = (STATE_W + 1)'(NUM_STATES);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [STATE_W-1:0] nxt;
    logic [OUT_W-1:0]   cur_out;
    logic               nxt_illegal;

    fsm_tbl_regs #(
        .IN_W        (IN_W),
        .OUT_W       (OUT_W),
        .NUM_STATES  (NUM_STATES),
        .STATE_W     (STATE_W),
        .RESET_STATE (RESET_STATE)
    ) u_tbl (
        .clk      (clk),
        .reset    (reset),
        .tr_we    (bus.cfg_tr_we),
        .out_we   (bus.cfg_out_we),
        .wr_state (bus.cfg_state),
        .wr_in    (bus.cfg_in),
        .wr_next  (bus.cfg_next),
        .wr_out   (bus.cfg_out),
        .rd_state (state_q),
        .rd_in    (bus.in),
        .rd_next  (nxt),
        .rd_out   (cur_out)
    );

    assign nxt_illegal = ({1'b0, nxt} >= NUM_ST_L);

    // Next state, count and error; an illegal step wins over err_clr.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        if (bus.err_clr) begin
            err_d = 1'b0;
        end
        if (bus.in_valid) begin
            if (nxt_illegal) begin
                state_d = RESET_STATE;
                err_d   = 1'b1;
            end else begin
                state_d = nxt;
            end
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // FSM registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.state    = state_q;
    assign bus.step_cnt = cnt_q;
    assign bus.err      = err_q;
    assign bus.out      = cur_out;

endmodule

// File: tb/tb_param_table_fsm.sv
// Directed bench for param_table_fsm: a default instance plus a
// 3-bit-counter instance for saturation.
module tb_param_table_fsm;
    import param_table_fsm_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    param_table_fsm_if                bus ();
    param_table_fsm_if #(.CNT_W(3))   bus3 ();

    param_table_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    param_table_fsm #(.CNT_W(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [1:0] sym);
        bus.in_valid = valid;
        bus.in       = sym;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic writeTr(input logic [2:0] s, input logic [1:0] i,
                           input logic [2:0] n);
        bus.cfg_tr_we = 1'b1;
        bus.cfg_state = s;
        bus.cfg_in    = i;
        bus.cfg_next  = n;
        tick();
        bus.cfg_tr_we = 1'b0;
    endtask

    task automatic writeOut(input logic [2:0] s, input logic [1:0] o);
        bus.cfg_out_we = 1'b1;
        bus.cfg_state  = s;
        bus.cfg_out    = o;
        tick();
        bus.cfg_out_we = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.in_valid = 0; bus.in = 0; bus.cfg_tr_we = 0; bus.cfg_out_we = 0;
        bus.cfg_state = 0; bus.cfg_in = 0; bus.cfg_next = 0; bus.cfg_out = 0;
        bus.err_clr = 0;
        bus3.in_valid = 0; bus3.in = 0; bus3.cfg_tr_we = 0; bus3.cfg_out_we = 0;
        bus3.cfg_state = 0; bus3.cfg_in = 0; bus3.cfg_next = 0; bus3.cfg_out = 0;
        bus3.err_clr = 0;

        // Reset held while symbols toggle
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = k[0];
            bus.in       = 2'(k);
            tick();
        end
        bus.in_valid = 0;
        checkOutput("rst_state", bus.state, S_A);
        checkOutput("rst_out", bus.out, 0);
        checkOutput("rst_cnt", bus.step_cnt, 0);
        checkOutput("rst_err", bus.err, 0);
        reset = 1'b1;
        tick();

        // Unprogrammed table keeps the machine at home
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 2'b11);
        checkOutput("unprog_state", bus.state, S_A);
        checkOutput("unprog_cnt", bus.step_cnt, 3);

        // Fresh reset, then program the five-state machine
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        writeTr(S_A, 2'b01, S_E);
        writeTr(S_E, 2'b00, S_E);
        writeTr(S_E, 2'b01, S_C);
        writeTr(S_C, 2'b11, S_B);
        writeTr(S_B, 2'b11, S_A);
        writeTr(S_A, 2'b10, S_B);
        writeOut(S_B, 2'b01);
        writeOut(S_C, 2'b10);
        writeOut(S_D, 2'b11);
        // Both writes in one cycle
        bus.cfg_tr_we = 1; bus.cfg_out_we = 1; bus.cfg_state = S_E;
        bus.cfg_in = 2'b10; bus.cfg_next = S_A; bus.cfg_out = 2'b11;
        tick();
        bus.cfg_tr_we = 0; bus.cfg_out_we = 0;
        checkOutput("prog_out_a", bus.out, 2'b00);

        applyStimulus(1, 2'b01); checkOutput("seq1_state", bus.state, S_E);
        checkOutput("seq1_out", bus.out, 2'b11);
        applyStimulus(1, 2'b00); checkOutput("seq2_state", bus.state, S_E);
        applyStimulus(1, 2'b01); checkOutput("seq3_state", bus.state, S_C);
        checkOutput("seq3_out", bus.out, 2'b10);
        applyStimulus(1, 2'b11); checkOutput("seq4_state", bus.state, S_B);
        applyStimulus(1, 2'b11); checkOutput("seq5_state", bus.state, S_A);
        checkOutput("seq5_out", bus.out, 2'b00);
        applyStimulus(1, 2'b10); checkOutput("seq6_state", bus.state, S_B);
        checkOutput("seq6_out", bus.out, 2'b01);
        checkOutput("seq_cnt", bus.step_cnt, 6);

        // Idle hold while the symbol wanders
        for (int k = 0; k < 4; k++) applyStimulus(0, 2'(k));
        checkOutput("idle_state", bus.state, S_B);
        checkOutput("idle_out", bus.out, 2'b01);
        checkOutput("idle_cnt", bus.step_cnt, 6);

        // Illegal entry taken from B
        writeTr(S_B, 2'b00, 3'd6);
        applyStimulus(1, 2'b00);
        checkOutput("illegal_state", bus.state, S_A);
        checkOutput("illegal_err", bus.err, 1);
        checkOutput("illegal_cnt", bus.step_cnt, 7);
        applyStimulus(0, 2'b00);
        checkOutput("err_sticky", bus.err, 1);
        bus.err_clr = 1;
        applyStimulus(0, 2'b00);
        bus.err_clr = 0;
        checkOutput("err_cleared", bus.err, 0);
        applyStimulus(1, 2'b10);
        checkOutput("back_to_b", bus.state, S_B);
        bus.err_clr = 1;
        applyStimulus(1, 2'b00);
        bus.err_clr = 0;
        checkOutput("set_wins_err", bus.err, 1);
        checkOutput("set_wins_state", bus.state, S_A);
        checkOutput("set_wins_cnt", bus.step_cnt, 9);

        // Same-cycle step and rewrite of the entry being taken
        applyStimulus(1, 2'b01);
        applyStimulus(1, 2'b01);
        checkOutput("at_c", bus.state, S_C);
        bus.cfg_tr_we = 1; bus.cfg_state = S_C; bus.cfg_in = 2'b11;
        bus.cfg_next = S_D;
        applyStimulus(1, 2'b11);
        bus.cfg_tr_we = 0;
        checkOutput("rbw_old_entry", bus.state, S_B);
        applyStimulus(1, 2'b11);
        applyStimulus(1, 2'b01);
        applyStimulus(1, 2'b01);
        applyStimulus(1, 2'b11);
        checkOutput("rbw_new_entry", bus.state, S_D);
        checkOutput("rbw_out_d", bus.out, 2'b11);
        checkOutput("rbw_cnt", bus.step_cnt, 16);
        applyStimulus(1, 2'b00);
        applyStimulus(1, 2'b10);
        checkOutput("at_b_again", bus.state, S_B);
        bus.cfg_out_we = 1; bus.cfg_state = S_B; bus.cfg_out = 2'b10;
        #2;
        checkOutput("out_before_edge", bus.out, 2'b01);
        tick();
        bus.cfg_out_we = 0;
        checkOutput("out_after_edge", bus.out, 2'b10);

        // Saturation on the 3-bit counter instance
        bus3.in_valid = 1;
        for (int k = 0; k < 7; k++) tick();
        checkOutput("sat_cnt7", bus3.step_cnt, 7);
        for (int k = 0; k < 3; k++) tick();
        bus3.in_valid = 0;
        checkOutput("sat_cnt10", bus3.step_cnt, 7);

        // Asynchronous reset between edges
        reset = 1'b0;
        #2;
        checkOutput("areset_state", bus.state, S_A);
        checkOutput("areset_out", bus.out, 0);
        checkOutput("areset_cnt", bus.step_cnt, 0);
        checkOutput("areset_err", bus.err, 0);
        checkOutput("areset_cnt3", bus3.step_cnt, 0);
        reset = 1'b1;
        tick();
        applyStimulus(1, 2'b10);
        checkOutput("areset_table", bus.state, S_A);
        checkOutput("areset_cnt_after", bus.step_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
